// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_unit_pkg;

    // MDU sequencing states
    typedef enum logic {
        IDLE     = 1'b0,
        MDU_BUSY = 1'b1
    } hazard_state_t;

    // Forwarding mux select encodings for the E-stage ALU operands
    localparam logic [1:0] FWD_REG = 2'b00;  // register file value
    localparam logic [1:0] FWD_W   = 2'b01;  // ResultW
    localparam logic [1:0] FWD_M   = 2'b10;  // ALUOutM

endpackage

// File: rtl/hazard_unit_forward_mux_sel.sv
// Forwarding select for one E-stage source operand. M beats W; register 0 is
// hard-wired zero and is never forwarded.
module forward_mux_sel
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic [REG_ADDR_W-1:0] write_reg_m,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] write_reg_w,
    input  logic                  reg_write_w,
    output logic [1:0]            sel
);

    // Pick the youngest in-flight producer of src
    always_comb begin
        sel = FWD_REG;
        if (reg_write_m && (write_reg_m != '0) && (write_reg_m == src))
            sel = FWD_M;
        else if (reg_write_w && (write_reg_w != '0) && (write_reg_w == src))
            sel = FWD_W;
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use stall, M-stage redirect
// flushes and MDU stall sequencing with a watchdog.
// Optional build macro HAZARD_PERF_EN adds StallCycles/FlushEvents counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int MDU_MAX_CYCLES = 64,
    parameter int PERF_W         = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] RsD,
    input  logic [REG_ADDR_W-1:0] RtD,
    input  logic [REG_ADDR_W-1:0] RsE,
    input  logic [REG_ADDR_W-1:0] RtE,
    input  logic [REG_ADDR_W-1:0] WriteRegE,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [REG_ADDR_W-1:0] WriteRegW,
    input  logic                  RegWriteE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemToRegE,
    input  logic                  branchM,
    input  logic                  ZeroM,
    input  logic                  jumpM,
    input  logic                  MduStartE,
    input  logic                  MduDoneE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  PCSrcM,
    output logic                  MduKill,
    output logic                  MduTimeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]     StallCycles,
    output logic [PERF_W-1:0]     FlushEvents
`endif
);

    localparam int              CNT_W   = $clog2(MDU_MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MDU_MAX_CYCLES);

    if (MDU_MAX_CYCLES < 2 || PERF_W < 1) begin : g_bad_cfg
        $error("hazard_unit: MDU_MAX_CYCLES must be >= 2 and PERF_W >= 1");
    end

    hazard_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_set;
    logic             stall_fd, stall_e, flush_d, flush_e, flush_m, kill;
    logic [1:0]       fwd_a, fwd_b;
    logic             pc_src, lwstall;

    // The load destination is RtE, so the E-stage write port is not consulted.
    logic unused_e_dest;
    assign unused_e_dest = ^{RegWriteE, WriteRegE};

    forward_mux_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src(RsE), .write_reg_m(WriteRegM), .reg_write_m(RegWriteM),
        .write_reg_w(WriteRegW), .reg_write_w(RegWriteW), .sel(fwd_a)
    );

    forward_mux_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src(RtE), .write_reg_m(WriteRegM), .reg_write_m(RegWriteM),
        .write_reg_w(WriteRegW), .reg_write_w(RegWriteW), .sel(fwd_b)
    );

    assign pc_src  = (branchM && ZeroM) || jumpM;
    assign lwstall = MemToRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));

    // Next-state and raw control: redirect > MDU start > load-use in IDLE.
    // On done or watchdog expiry the stalls drop so the MDU op leaves E.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        stall_fd    = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        kill        = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (pc_src) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    flush_m = 1'b1;
                    kill    = MduStartE;
                end else if (MduStartE && !MduDoneE) begin
                    stall_fd  = 1'b1;
                    stall_e   = 1'b1;
                    flush_m   = 1'b1;
                    state_nxt = MDU_BUSY;
                    cnt_nxt   = CNT_W'(1);
                end else if (lwstall) begin
                    stall_fd = 1'b1;
                    flush_e  = 1'b1;
                end
            end
            MDU_BUSY: begin
                if (MduDoneE) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_MAX) begin
                    kill        = 1'b1;
                    timeout_set = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    stall_fd = 1'b1;
                    stall_e  = 1'b1;
                    flush_m  = 1'b1;
                    cnt_nxt  = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, busy counter and sticky watchdog flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            MduTimeout <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (timeout_set) MduTimeout <= 1'b1;
        end
    end

    // While reset is high, hold the pipeline in bubbles with no side effects
    always_comb begin
        StallF    = !reset && stall_fd;
        StallD    = !reset && stall_fd;
        StallE    = !reset && stall_e;
        FlushD    = reset || flush_d;
        FlushE    = reset || flush_e;
        FlushM    = reset || flush_m;
        ForwardAE = reset ? FWD_REG : fwd_a;
        ForwardBE = reset ? FWD_REG : fwd_b;
        PCSrcM    = !reset && pc_src;
        MduKill   = !reset && kill;
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCycles <= '0;
            FlushEvents <= '0;
        end else begin
            if ((StallF || StallD || StallE) && (StallCycles != '1))
                StallCycles <= StallCycles + PERF_W'(1);
            if (PCSrcM && (FlushEvents != '1))
                FlushEvents <= FlushEvents + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed scenarios then random traffic,
// expectations from a cycle-level behavioural model of the hazard rules.
module tb_hazard_unit;

    localparam int MAXC = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE;
    logic       branchM, ZeroM, jumpM, MduStartE, MduDoneE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       PCSrcM, MduKill, MduTimeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCycles, FlushEvents;
`endif

    hazard_unit #(.REG_ADDR_W(5), .MDU_MAX_CYCLES(MAXC), .PERF_W(32)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .branchM(branchM), .ZeroM(ZeroM), .jumpM(jumpM),
        .MduStartE(MduStartE), .MduDoneE(MduDoneE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .PCSrcM(PCSrcM), .MduKill(MduKill), .MduTimeout(MduTimeout)
`ifdef HAZARD_PERF_EN
        , .StallCycles(StallCycles), .FlushEvents(FlushEvents)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sf, sd, se, fd, fe, fm;
        logic [1:0]  fa, fb;
        logic        pc, kill, to;
        logic [31:0] sc, fl;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Behavioural model state
    bit          m_busy = 0;
    int          m_cnt = 0;
    bit          m_to = 0;
    int unsigned m_sc = 0;
    int unsigned m_fl = 0;

    function automatic logic [1:0] fwd(int src, bit wm, int rm, bit ww, int rw);
        if (src != 0 && wm && rm == src) return 2'b10;
        if (src != 0 && ww && rw == src) return 2'b01;
        return 2'b00;
    endfunction

    // Expected outputs for the inputs now applied, then advance the model one edge
    task automatic step();
        exp_t e;
        bit   pc, lw;
        e = '0;
        e.to = m_to;
        e.sc = m_sc;
        e.fl = m_fl;
        if (reset) begin
            e.fd = 1; e.fe = 1; e.fm = 1;
            m_busy = 0; m_cnt = 0; m_to = 0; m_sc = 0; m_fl = 0;
        end else begin
            e.fa = fwd(int'(RsE), RegWriteM, int'(WriteRegM), RegWriteW, int'(WriteRegW));
            e.fb = fwd(int'(RtE), RegWriteM, int'(WriteRegM), RegWriteW, int'(WriteRegW));
            pc = (branchM && ZeroM) || jumpM;
            lw = MemToRegE && RtE != 0 && (RtE == RsD || RtE == RtD);
            e.pc = pc;
            if (m_busy) begin
                if (MduDoneE) m_busy = 0;
                else if (m_cnt == MAXC) begin
                    e.kill = 1; m_to = 1; m_busy = 0; m_cnt = 0;
                end else begin
                    e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1; m_cnt++;
                end
            end else if (pc) begin
                e.fd = 1; e.fe = 1; e.fm = 1; e.kill = MduStartE;
            end else if (MduStartE && !MduDoneE) begin
                e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1; m_busy = 1; m_cnt = 1;
            end else if (lw) begin
                e.sf = 1; e.sd = 1; e.fe = 1;
            end
            if ((e.sf || e.sd || e.se) && m_sc != 32'hFFFF_FFFF) m_sc++;
            if (pc && m_fl != 32'hFFFF_FFFF) m_fl++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemToRegE} = '0;
        {branchM, ZeroM, jumpM, MduStartE, MduDoneE} = '0;
    endtask

    // Monitor: every cycle presents a response; compare mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [14:0] av, ev;
            e  = q.pop_front();
            av = {StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
                  PCSrcM, MduKill, MduTimeout};
            ev = {e.sf, e.sd, e.se, e.fd, e.fe, e.fm, e.fa, e.fb, e.pc, e.kill, e.to};
            total++;
            if (av !== ev) begin
                bad++;
                $display("FAIL ctrl @%0t: got sf/sd/se/fd/fe/fm/fa/fb/pc/kill/to=%b want %b",
                         $time, av, ev);
            end
`ifdef HAZARD_PERF_EN
            total++;
            if (StallCycles !== e.sc || FlushEvents !== e.fl) begin
                bad++;
                $display("FAIL perf @%0t: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         $time, StallCycles, FlushEvents, e.sc, e.fl);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        repeat (2) step();
        reset = 0;

        // Forwarding: M, W only, M beats W, $0 never forwarded
        RegWriteM = 1; WriteRegM = 3; RsE = 3; step();
        RegWriteM = 0; RegWriteW = 1; WriteRegW = 3; RtE = 3; step();
        RegWriteM = 1; step();
        WriteRegM = 0; WriteRegW = 0; RsE = 0; RtE = 0; step();
        clear_inputs();

        // Load-use one cycle, then clear
        MemToRegE = 1; RtE = 5; RtD = 5; step();
        clear_inputs(); step();

        // Taken branch coinciding with load-use
        MemToRegE = 1; RtE = 5; RsD = 5; branchM = 1; ZeroM = 1; step();
        clear_inputs(); step();

        // MDU completes on the 6th cycle
        MduStartE = 1;
        repeat (5) step();
        MduDoneE = 1; step();
        clear_inputs(); step();

        // MDU never completes: watchdog kill at count MAXC, sticky timeout
        MduStartE = 1;
        repeat (MAXC + 1) step();
        clear_inputs();
        repeat (3) step();

        // Reset in the middle of an MDU op
        MduStartE = 1;
        repeat (3) step();
        reset = 1; step();
        reset = 0; clear_inputs();
        repeat (2) step();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            RsD = 5'($urandom_range(0, 7)); RtD = 5'($urandom_range(0, 7));
            RsE = 5'($urandom_range(0, 7)); RtE = 5'($urandom_range(0, 7));
            WriteRegE = 5'($urandom_range(0, 7));
            WriteRegM = 5'($urandom_range(0, 7));
            WriteRegW = 5'($urandom_range(0, 7));
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            MemToRegE = ($urandom_range(0, 2) == 0);
            if (m_busy) begin
                branchM = 0; jumpM = 0; ZeroM = 1'($urandom);
                MduStartE = 1;
                MduDoneE = ($urandom_range(0, 5) == 0);
            end else begin
                branchM = ($urandom_range(0, 5) == 0);
                ZeroM = 1'($urandom);
                jumpM = ($urandom_range(0, 9) == 0);
                MduStartE = ($urandom_range(0, 7) == 0);
                MduDoneE = ($urandom_range(0, 3) == 0);
                if (MduStartE) MemToRegE = 0;
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 0;
        clear_inputs();
        step();

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
